// File: rtl/status_flag_unit_if.sv
// Flag-unit bus: ALU execute-stage info, direct flag load and flush in,
// architectural N/Z/C/V and busy out. Master drives the execute side.
interface status_flag_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             alu_valid;
  logic             s_bit;
  logic [1:0]       op_class;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             shifter_carry;
  logic             load_en;
  logic [3:0]       load_flags;
  logic             flush;
  logic             N;
  logic             Z;
  logic             C;
  logic             V;
  logic             flags_busy;

  modport master (
    output alu_valid, s_bit, op_class, a, b, result, shifter_carry,
    output load_en, load_flags, flush,
    input  N, Z, C, V, flags_busy
  );

  modport slave (
    input  alu_valid, s_bit, op_class, a, b, result, shifter_carry,
    input  load_en, load_flags, flush,
    output N, Z, C, V, flags_busy
  );
endinterface

// File: rtl/status_flag_unit.sv
// Status flag unit: derives N/Z/C/V candidates from the ALU, holds them in a
// one-entry pending stage and commits them into the architectural flags one
// edge later. Supports direct flag load and flush.
// Optional macro FLAG_BYPASS_EN: forward pending flags onto the outputs and
// tie flags_busy low.
module status_flag_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  status_flag_unit_if.slave bus
);

  localparam logic [1:0] OpLogic = 2'b00;
  localparam logic [1:0] OpAdd   = 2'b01;
  localparam logic [1:0] OpSub   = 2'b10;
  localparam logic [1:0] OpShift = 2'b11;

  // Flag vectors are ordered {N, Z, C, V}.
  logic       pend_valid_q, pend_valid_d;
  logic [3:0] pend_flags_q, pend_flags_d;
  logic [3:0] pend_mask_q,  pend_mask_d;
  logic [3:0] flags_q,      flags_d;

  logic [3:0] cand_flags;
  logic [3:0] cand_mask;
  logic       capture;
  logic [3:0] committed;

  // Candidate flags and write mask decoded from the ALU op class.
  always_comb begin
    cand_flags    = '0;
    cand_mask     = '0;
    cand_flags[3] = bus.result[WIDTH-1];
    cand_flags[2] = (bus.result == '0);
    unique case (bus.op_class)
      OpLogic: begin
        cand_mask = 4'b1100;
      end
      OpAdd: begin
        cand_mask     = 4'b1111;
        // Carry out of an unsigned add shows up as a wrap-around.
        cand_flags[1] = ((bus.a + bus.b) < bus.a);
        cand_flags[0] = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                        (bus.result[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpSub: begin
        cand_mask     = 4'b1111;
        // ARM-style carry: set when no borrow.
        cand_flags[1] = (bus.a >= bus.b);
        cand_flags[0] = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                        (bus.result[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpShift: begin
        cand_mask     = 4'b1110;
        cand_flags[1] = bus.shifter_carry;
      end
      default: begin
        cand_mask = '0;
      end
    endcase
  end

  assign capture   = bus.alu_valid && bus.s_bit && !bus.load_en && !bus.flush;
  assign committed = (flags_q & ~pend_mask_q) | (pend_flags_q & pend_mask_q);

  // Next-state: flush beats load, load beats commit/capture.
  always_comb begin
    pend_valid_d = 1'b0;
    pend_flags_d = pend_flags_q;
    pend_mask_d  = pend_mask_q;
    flags_d      = flags_q;
    if (bus.flush) begin
      pend_valid_d = 1'b0;
    end else if (bus.load_en) begin
      // Load is younger than anything pending, so the pending entry dies.
      flags_d      = bus.load_flags;
      pend_valid_d = 1'b0;
    end else begin
      if (pend_valid_q) begin
        flags_d = committed;
      end
      if (capture) begin
        pend_valid_d = 1'b1;
        pend_flags_d = cand_flags;
        pend_mask_d  = cand_mask;
      end
    end
  end

  // Pending stage and architectural flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_flags_q <= '0;
      pend_mask_q  <= '0;
      flags_q      <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_flags_q <= pend_flags_d;
      pend_mask_q  <= pend_mask_d;
      flags_q      <= flags_d;
    end
  end

`ifdef FLAG_BYPASS_EN
  // Forward the pending update so consumers see it one edge earlier.
  always_comb begin
    {bus.N, bus.Z, bus.C, bus.V} = pend_valid_q ? committed : flags_q;
    bus.flags_busy               = 1'b0;
  end
`else
  // Outputs show the architectural register; busy mirrors the pending stage.
  always_comb begin
    {bus.N, bus.Z, bus.C, bus.V} = flags_q;
    bus.flags_busy               = pend_valid_q;
  end
`endif

endmodule

// File: tb/tb_status_flag_unit.sv
// Scoreboard bench for status_flag_unit: stimulus pushes expected
// {N,Z,C,V,busy} tagged with the cycle it must appear; a monitor pops and
// compares just after each rising edge.
module tb_status_flag_unit;

  localparam int unsigned W = 32;

  logic clk;
  logic reset;

  status_flag_unit_if #(.WIDTH(W)) bus ();

  status_flag_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [4:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got NZCV_busy=%b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] observed();
    return {bus.N, bus.Z, bus.C, bus.V, bus.flags_busy};
  endfunction

  // Monitor: count edges and retire expectations due this cycle.
  always @(posedge clk) begin
    #1;
    cyc++;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      if (exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: missed slot, due cycle %0d now %0d", exp_q[0].name,
                 exp_q[0].cyc, cyc);
      end else begin
        check(exp_q[0].name, observed(), exp_q[0].exp);
      end
      void'(exp_q.pop_front());
    end
  end

  task automatic expect_at(input int c, input string name, input logic [4:0] e);
    exp_t x;
    x.cyc  = c;
    x.name = name;
    x.exp  = e;
    exp_q.push_back(x);
  endtask

  task automatic idle();
    bus.alu_valid     = 1'b0;
    bus.s_bit         = 1'b0;
    bus.op_class      = 2'b00;
    bus.a             = '0;
    bus.b             = '0;
    bus.result        = '0;
    bus.shifter_carry = 1'b0;
    bus.load_en       = 1'b0;
    bus.load_flags    = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] r, input logic sc, input logic s);
    bus.alu_valid     = 1'b1;
    bus.s_bit         = s;
    bus.op_class      = op;
    bus.a             = a;
    bus.b             = b;
    bus.result        = r;
    bus.shifter_carry = sc;
  endtask

  // Step to the next falling edge; inputs driven after this are sampled at edge cyc+1.
  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  initial begin
    int c;
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_state", observed(), 5'b0000_0);
    reset = 1'b0;

    // Test 1: signed overflow add.
    nxt(); c = cyc;
    alu(2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    expect_at(c + 1, "t1_pending", 5'b0000_1);
    expect_at(c + 2, "t1_commit", 5'b1001_0);
    nxt(); nxt();

    // Test 2: back-to-back subs.
    nxt(); c = cyc;
    alu(2'b10, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1);
    expect_at(c + 2, "t2_sub_eq", 5'b0110_1);
    nxt();
    alu(2'b10, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b1);
    expect_at(c + 3, "t2_sub_borrow", 5'b1000_0);
    nxt(); nxt();

    // Test 3: add with carry, then logic op keeps C and V.
    nxt(); c = cyc;
    alu(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);
    expect_at(c + 2, "t3_add_carry", 5'b0110_1);
    nxt();
    alu(2'b00, 32'h0, 32'h0, 32'h0000_0001, 1'b1, 1'b1);
    expect_at(c + 3, "t3_logic", 5'b0010_0);
    nxt(); nxt();

    // Test 6: async reset while an update is pending.
    nxt(); c = cyc;
    alu(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1);
    expect_at(c + 1, "t6_pending", 5'b0010_1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check("t6_async_reset", observed(), 5'b0000_0);
    nxt();
    reset = 1'b0;
    c = cyc;
    expect_at(c + 1, "t6_no_commit_a", 5'b0000_0);
    expect_at(c + 2, "t6_no_commit_b", 5'b0000_0);
    nxt(); nxt();

    // Test 4: flush cancels the pending update.
    nxt(); c = cyc;
    alu(2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    expect_at(c + 1, "t4_pending", 5'b0000_1);
    nxt();
    bus.flush = 1'b1;
    alu(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 1'b1);
    expect_at(c + 2, "t4_flushed", 5'b0000_0);
    expect_at(c + 3, "t4_hold", 5'b0000_0);
    nxt(); nxt();

    // Test 5: load discards pending and ignores same-cycle ALU capture.
    nxt(); c = cyc;
    alu(2'b10, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1);
    expect_at(c + 1, "t5_pending", 5'b0000_1);
    nxt();
    bus.load_en    = 1'b1;
    bus.load_flags = 4'b1011;
    alu(2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    expect_at(c + 2, "t5_load", 5'b1011_0);
    expect_at(c + 3, "t5_hold", 5'b1011_0);
    nxt(); nxt();

    // s_bit=0 does not capture but the previous entry still commits.
    nxt(); c = cyc;
    alu(2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    nxt();
    alu(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
    expect_at(c + 2, "nos_commit", 5'b1001_0);
    nxt(); nxt();

    // Shift writes N,Z,C from the shifter carry and leaves V alone.
    nxt(); c = cyc;
    alu(2'b11, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    expect_at(c + 2, "shift", 5'b0111_0);
    nxt(); nxt(); nxt();

    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never checked, due cycle %0d", exp_q[0].name, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish by 20000");
    $fatal(1);
  end

endmodule
